// File: rtl/viterbi_pkg.sv
// Shared definitions for the convolutional encoder and the Viterbi decoder.
// Both ends of the link import the same code constants so the trellis agrees.
//
// Contents:
//   K, M          constraint length and number of memory bits
//   G0_OCT/G1_OCT generator polynomials in octal (bit i taps register bit i)
//   enc_state_t   encoder framing FSM states
//   conv_sym      one rate-1/2 encode step for a K-bit shift register image
package viterbi_pkg;

    localparam int         K      = 3;
    localparam int         M      = K - 1;
    localparam logic [7:0] G0_OCT = 8'o07;
    localparam logic [7:0] G1_OCT = 8'o05;

    typedef enum logic {
        DATA = 1'b0,
        TAIL = 1'b1
    } enc_state_t;

    // sr = {state[M-1:0], new_bit}; returns {g0 parity, g1 parity}.
    function automatic logic [1:0] conv_sym(logic [K-1:0] sr);
        logic [K-1:0] g0;
        logic [K-1:0] g1;
        g0 = G0_OCT[K-1:0];
        g1 = G1_OCT[K-1:0];
        return {^(sr & g0), ^(sr & g1)};
    endfunction

endpackage

// File: rtl/conv_encoder_framer.sv
// Rate-1/2 convolutional encoder with frame tail insertion.
// Accepts one information bit per input handshake and emits one 2-bit symbol
// per output handshake. After the bit flagged in_bit_last, M zero tail bits
// are encoded so the decoder trellis terminates in state 0.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   in_bit_valid  upstream bit valid
//   in_bit_ready  block accepts a bit this cycle
//   in_bit        information bit
//   in_bit_last   marks the final information bit of a frame
//   sym_valid     output symbol valid
//   sym_ready     downstream ready
//   sym           encoded symbol {g0 parity, g1 parity}
//   sym_last      marks the final tail symbol of a frame
//   busy          high from first accepted bit until the last tail symbol fires
module conv_encoder_framer
    import viterbi_pkg::enc_state_t;
    import viterbi_pkg::DATA;
    import viterbi_pkg::TAIL;
#(
    parameter int         K      = viterbi_pkg::K,
    parameter logic [7:0] G0_OCT = viterbi_pkg::G0_OCT,
    parameter logic [7:0] G1_OCT = viterbi_pkg::G1_OCT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_bit_valid,
    output logic       in_bit_ready,
    input  logic       in_bit,
    input  logic       in_bit_last,
    output logic       sym_valid,
    input  logic       sym_ready,
    output logic [1:0] sym,
    output logic       sym_last,
    output logic       busy
);

    localparam int M   = K - 1;
    localparam int TCW = $clog2(M) + 1;

    // Same computation as viterbi_pkg::conv_sym, but bound to this instance's
    // parameters so a non-default code still encodes consistently.
    function automatic logic [1:0] encode(logic [K-1:0] sr);
        logic [K-1:0] g0;
        logic [K-1:0] g1;
        g0 = G0_OCT[K-1:0];
        g1 = G1_OCT[K-1:0];
        return {^(sr & g0), ^(sr & g1)};
    endfunction

    enc_state_t       fsm;
    logic [M-1:0]     state;
    logic [TCW-1:0]   tail_cnt;

    logic             load_ok;
    logic             fire;
    logic             tail_go;
    logic             sym_fire;
    logic [K-1:0]     sr_data;
    logic [K-1:0]     sr_tail;

    // Output register may take a new symbol when empty or being drained now.
    assign load_ok  = !sym_valid || sym_ready;
    // Held low during reset so nothing upstream is consumed while rst is high.
    assign in_bit_ready = !rst && (fsm == DATA) && load_ok;
    assign fire     = in_bit_valid && in_bit_ready;
    assign tail_go  = (fsm == TAIL) && load_ok;
    assign sym_fire = sym_valid && sym_ready;

    assign sr_data = {state, in_bit};
    assign sr_tail = {state, 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= DATA;
            state     <= '0;
            tail_cnt  <= '0;
            sym       <= '0;
            sym_valid <= 1'b0;
            sym_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // Clear first so a new frame's first fire on the same edge wins.
            if (sym_fire && sym_last) begin
                busy <= 1'b0;
            end

            if (fire) begin
                sym       <= encode(sr_data);
                state     <= sr_data[M-1:0];
                sym_valid <= 1'b1;
                sym_last  <= 1'b0;
                busy      <= 1'b1;
                if (in_bit_last) begin
                    fsm      <= TAIL;
                    tail_cnt <= '0;
                end
            end else if (tail_go) begin
                sym       <= encode(sr_tail);
                state     <= sr_tail[M-1:0];
                sym_valid <= 1'b1;
                tail_cnt  <= tail_cnt + 1'b1;
                if (tail_cnt == TCW'(M - 1)) begin
                    // M zeros have flushed the register, so state is 0 here.
                    sym_last <= 1'b1;
                    fsm      <= DATA;
                end else begin
                    sym_last <= 1'b0;
                end
            end else if (sym_fire) begin
                sym_valid <= 1'b0;
                sym_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_encoder_framer.sv
module tb_conv_encoder_framer;

    localparam int M = 2;

    logic       clk;
    logic       rst;
    logic       in_bit_valid;
    logic       in_bit_ready;
    logic       in_bit;
    logic       in_bit_last;
    logic       sym_valid;
    logic       sym_ready;
    logic [1:0] sym;
    logic       sym_last;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Each entry: {sym[1:0], sym_last}
    logic [2:0] q[$];

    conv_encoder_framer dut (
        .clk          (clk),
        .rst          (rst),
        .in_bit_valid (in_bit_valid),
        .in_bit_ready (in_bit_ready),
        .in_bit       (in_bit),
        .in_bit_last  (in_bit_last),
        .sym_valid    (sym_valid),
        .sym_ready    (sym_ready),
        .sym          (sym),
        .sym_last     (sym_last),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pushc(input logic [1:0] s, input logic l);
        q.push_back({s, l});
    endtask

    // Independent K=3, G0=7, G1=5 model written out as explicit tap equations.
    task automatic push_model(input logic [31:0] bits, input logic [31:0] lastm, input int len);
        logic [1:0] st;
        logic       b;
        st = 2'b00;
        for (int i = 0; i < len; i++) begin
            b = bits[i];
            q.push_back({b ^ st[1] ^ st[0], b ^ st[1], 1'b0});
            st = {st[0], b};
            if (lastm[i]) begin
                for (int t = 0; t < M; t++) begin
                    b = 1'b0;
                    q.push_back({b ^ st[1] ^ st[0], b ^ st[1], (t == M - 1)});
                    st = {st[0], b};
                end
            end
        end
    endtask

    function automatic logic rdy(input int mode, input int c);
        if (mode == 1) return ((c % 4) == 0) || ((c % 4) == 3);
        if (mode == 2) return 1'(($urandom_range(0, 1)));
        return 1'b1;
    endfunction

    // Drives a bit sequence and checks every consumed symbol against the queue.
    // mode: 0 ready held high, 1 pattern 1,0,0,1,..., 2 random ready.
    task automatic run(input logic [31:0] bits, input logic [31:0] lastm, input int len,
                       input int mode, input bit nobubble, output int busy_cycles);
        int         idx;
        int         guard;
        int         tail_rem;
        int         c;
        bit         fired;
        bit         started;
        bit         stall;
        logic [1:0] held;
        logic [2:0] e;
        idx = 0; guard = 0; tail_rem = 0; c = 0;
        started = 0; stall = 0; held = 2'b00; busy_cycles = 0;
        in_bit_valid = (idx < len);
        in_bit       = bits[idx];
        in_bit_last  = lastm[idx];
        sym_ready    = rdy(mode, c);
        while ((idx < len || q.size() > 0) && guard < 400) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (stall) chk("stall_hold", int'(sym), int'(held));
            if (sym_valid && !sym_ready) chk("ready_in_stall", int'(in_bit_ready), 0);
            if (mode == 0) chk("tail_ready", int'(in_bit_ready), int'(tail_rem == 0));
            if (nobubble && started && q.size() > 0) chk("no_bubble", int'(sym_valid), 1);
            if (sym_valid && sym_ready) begin
                if (q.size() == 0) begin
                    chk("extra_sym", int'(sym_valid), 0);
                end else begin
                    e = q.pop_front();
                    chk("sym", int'(sym), int'(e[2:1]));
                    chk("sym_last", int'(sym_last), int'(e[0]));
                end
                started = 1;
            end
            stall = sym_valid && !sym_ready;
            held  = sym;
            fired = in_bit_valid && in_bit_ready;
            @(posedge clk);
            #1;
            if (fired && lastm[idx]) tail_rem = M;
            else if (tail_rem > 0) tail_rem--;
            if (fired) idx++;
            c++;
            guard++;
            in_bit_valid = (idx < len);
            in_bit       = (idx < len) ? bits[idx] : 1'b0;
            in_bit_last  = (idx < len) ? lastm[idx] : 1'b0;
            sym_ready    = rdy(mode, c);
        end
        chk("pending_work", q.size() + (len - idx), 0);
        q.delete();
        in_bit_valid = 1'b0;
        in_bit_last  = 1'b0;
        sym_ready    = 1'b1;
    endtask

    initial begin
        int bc;
        logic [31:0] rb;

        rst = 1'b1; in_bit_valid = 1'b0; in_bit = 1'b0; in_bit_last = 1'b0; sym_ready = 1'b1;
        #2;
        chk("rst_in_ready", int'(in_bit_ready), 0);
        chk("rst_sym_valid", int'(sym_valid), 0);
        chk("rst_sym", int'(sym), 0);
        chk("rst_sym_last", int'(sym_last), 0);
        chk("rst_busy", int'(busy), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_rst_ready", int'(in_bit_ready), 1);

        // Frame 1,1,1,1
        pushc(2'b11, 0); pushc(2'b01, 0); pushc(2'b10, 0); pushc(2'b10, 0);
        pushc(2'b01, 0); pushc(2'b11, 1);
        @(posedge clk); #1;
        run(32'b1111, 32'b1000, 4, 0, 1'b0, bc);
        chk("busy_cycles_1111", bc, 6);

        // Frame 0,0,0 then frame 1
        repeat (2) pushc(2'b00, 0);
        repeat (2) pushc(2'b00, 0);
        pushc(2'b00, 1);
        run(32'b000, 32'b100, 3, 0, 1'b0, bc);
        pushc(2'b11, 0); pushc(2'b10, 0); pushc(2'b11, 1);
        run(32'b1, 32'b1, 1, 0, 1'b0, bc);

        // Frame 1,0,1,1 with ready toggling 1,0,0,1
        pushc(2'b11, 0); pushc(2'b10, 0); pushc(2'b00, 0); pushc(2'b01, 0);
        pushc(2'b01, 0); pushc(2'b11, 1);
        run(32'b1101, 32'b1000, 4, 1, 1'b0, bc);

        // Mid-frame reset after 2 bits
        @(posedge clk); #1;
        in_bit_valid = 1'b1; in_bit = 1'b1; in_bit_last = 1'b0; sym_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        in_bit_valid = 1'b0;
        chk("pre_rst_valid", int'(sym_valid), 1);
        chk("pre_rst_busy", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", int'(sym_valid), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_ready", int'(in_bit_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_release_ready", int'(in_bit_ready), 1);
        pushc(2'b11, 0); pushc(2'b10, 0); pushc(2'b11, 1);
        run(32'b1, 32'b1, 1, 0, 1'b0, bc);

        // Back-to-back frames 1,0,1 | 0,1,1,0 with valid held high
        push_model(32'b0110101, 32'b1000100, 7);
        run(32'b0110101, 32'b1000100, 7, 0, 1'b1, bc);

        // Random frames under random backpressure
        for (int f = 0; f < 3; f++) begin
            rb = {24'h0, 8'($urandom_range(0, 255))};
            push_model(rb, 32'h80, 8);
            run(rb, 32'h80, 8, 2, 1'b0, bc);
        end

        @(posedge clk); #1;
        chk("idle_busy", int'(busy), 0);
        chk("idle_sym_valid", int'(sym_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_encoder_framer.md
# conv_encoder_framer

Rate-1/2 convolutional encoder with frame tail insertion, sitting directly upstream of `tt_um_viterbi_core`. It accepts one information bit per handshake and emits one 2-bit symbol per handshake, in the exact format `rx_sym` expects. After each frame's last bit it appends M = K-1 zero tail bits, so the decoder's trellis terminates in state 0. Output is a single registered stage with a valid/ready handshake.

## Interface
- `K`, 3: constraint length; M = K-1 memory bits.
- `G0_OCT`, 8'o07: generator 0, octal; bit i taps register bit i.
- `G1_OCT`, 8'o05: generator 1, octal.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_bit_valid`  in  1  upstream bit valid.
- `in_bit_ready`  out  1  block accepts a bit this cycle.
- `in_bit`  in  1  information bit.
- `in_bit_last`  in  1  qualifies `in_bit` as the final bit of a frame.
- `sym_valid`  out  1  symbol valid; connects to `rx_sym_valid`.
- `sym_ready`  in  1  downstream ready; connects to `rx_sym_ready`.
- `sym`  out  2  encoded symbol; connects to `rx_sym`.
- `sym_last`  out  1  marks the final tail symbol of a frame.
- `busy`  out  1  high from the first accepted bit of a frame until its last tail symbol is handed off.

## Operation
- Shift register `sr[K-1:0]` = {state[M-1:0], new_bit}; the new bit enters at the LSB. `state` resets to 0.
- Encoding: `sym[1]` = XOR-reduce(`sr` & G0[K-1:0]) and `sym[0]` = XOR-reduce(`sr` & G1[K-1:0]).
- After each encode, `state` <= `sr[M-1:0]`.
- FSM states:
  - DATA: idle, or inside a frame.
  - TAIL: injecting zeros.
- DATA behaviour:
  - On input fire, encode `in_bit` and load the output register.
  - If `in_bit_last`, go to TAIL with `tail_cnt` = 0.
- TAIL behaviour:
  - `in_bit_ready` = 0.
  - Each time the output register can load, encode bit 0 and increment `tail_cnt`.
  - On the encode with `tail_cnt` = M-1, set `sym_last`=1 and return to DATA. `state` is 0 by construction after M zero bits.
- Output register can load when `!sym_valid || sym_ready`.
  - `in_bit_ready` = (FSM==DATA) && load-allowed.
  - Input fire = `in_bit_valid && in_bit_ready`.
- `sym`, `sym_last`, and `sym_valid` hold stable while `sym_valid && !sym_ready`. The upstream bit is not consumed during that time.
- `busy`:
  - Set on the first fire of a frame.
  - Cleared when the `sym_last` symbol fires downstream.
- A single-bit frame (`in_bit_last` on the first bit) is legal and produces 1+M symbols.

## Timing
- Reset values (asynchronous, immediate): `sym_valid`=0, `sym`=0, `sym_last`=0, `busy`=0, `in_bit_ready`=0 while `rst` is high, `state`=0, FSM=DATA, `tail_cnt`=0.
- Latency: a bit accepted at edge N presents its symbol on `sym` with `sym_valid`=1 from edge N until consumed.
- Throughput: 1 symbol/clock with `sym_ready` held high. A frame of L bits occupies L+M consecutive symbol cycles, and the next frame's first bit can be accepted on the cycle after the last tail symbol is loaded.
- Simultaneous consume and load: the output register is replaced in the same edge, with no bubble.
- `sym_ready` low during TAIL: the tail count freezes and no tail bit is skipped or duplicated.
- `rst` mid-frame: the frame is discarded, no tail is emitted, and the block is ready for a fresh frame on the first edge after deassertion.
- `tail_cnt` width is $clog2(M)+1. `K`=2 (M=1) must work.

## Structure
- Shared package `viterbi_pkg`:
  - Constants `K`, `M`, `G0_OCT`, `G1_OCT`, shared with the decoder so both ends agree.
  - `function automatic logic [1:0] conv_sym(logic [K-1:0] sr)`, also usable by the reference model in benches.
  - State enum `enc_state_t` {DATA, TAIL}.
- No sub-module: the encode step is the package function, and FSM plus output register live in one module.

## Test plan
- Frame 1,1,1,1 (last on the 4th bit), `sym_ready`=1 → symbols 11,01,10,10,01,11 with `sym_last` on the 6th symbol only. `busy` is high for 6 cycles.
- Frame 0,0,0 → 00,00,00,00,00. Then frame 1 → 11,10,11, confirming `state` returned to 0 between frames.
- Frame 1,0,1,1 with `sym_ready` toggling 1,0,0,1,… → identical symbol sequence 11,10,00,01,01,11. `sym` is stable during every stall, and `in_bit_ready`=0 whenever `sym_valid && !sym_ready`.
- Assert `rst` after 2 bits of a frame → `sym_valid` drops immediately. Then a frame of 1 → 11,10,11.
- End-to-end: encoder → `tt_um_viterbi_core`, 16 random frames of 8 bits, no errors → decoded bits equal the sent bits, tails excluded.
- Back-to-back frames with `in_bit_valid` held high → no idle symbol cycle between frames, and `in_bit_ready`=0 exactly during the M tail cycles.
